pipe_buf_stage: RTL and testbench

PIPE_BUF_STAGE -- requirements
Module: pipe_buf_stage

---
 rtl/pipe_buf_pkg.sv | 19 +
 rtl/pipe_buf_sat_cnt.sv | 30 +++
 rtl/pipe_buf_stage.sv | 106 ++++++++++
 tb/tb_pipe_buf_stage.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/pipe_buf_pkg.sv
// Shared constants and pointer type for the pipe_buf_stage elastic buffer.
package pipe_buf_pkg;

    localparam int PIPE_BUF_DEF_WIDTH = 32;
    localparam int PIPE_BUF_DEF_DEPTH = 2;
    localparam int PIPE_BUF_DEF_CNT_W = 16;
    localparam int PIPE_BUF_MAX_DEPTH = 8;

    typedef logic [$clog2(PIPE_BUF_MAX_DEPTH)-1:0] pipe_buf_ptr_t;

    // Explicit compare-and-clear so non-power-of-two depths wrap correctly.
    function automatic pipe_buf_ptr_t pipe_buf_ptr_inc(input pipe_buf_ptr_t p, input int unsigned depth);
        if (32'(p) == depth - 1) begin
            return '0;
        end
        return p + pipe_buf_ptr_t'(1);
    endfunction

endpackage

// File: rtl/pipe_buf_sat_cnt.sv
// Saturating up-counter used for the optional pipe_buf_stage performance counters.
module pipe_buf_sat_cnt #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (en_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_buf_stage.sv
// Registered circular-buffer pipeline stage with valid/ready on both sides.
// Define PIPE_BUF_PERF_EN to add the stall_cnt/bubble_cnt performance counters.
module pipe_buf_stage
    import pipe_buf_pkg::*;
#(
    parameter int WIDTH = PIPE_BUF_DEF_WIDTH,
    parameter int DEPTH = PIPE_BUF_DEF_DEPTH,
    parameter int CNT_W = PIPE_BUF_DEF_CNT_W
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
`ifdef PIPE_BUF_PERF_EN
    ,
    output logic [CNT_W-1:0]           stall_cnt,
    output logic [CNT_W-1:0]           bubble_cnt
`endif
);

    localparam int OCC_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    if (WIDTH < 1 || WIDTH > 512 || DEPTH < 1 || DEPTH > PIPE_BUF_MAX_DEPTH || CNT_W < 1) begin : g_param_err
        $error("pipe_buf_stage: parameter out of range");
    end

    pipe_buf_ptr_t    head_q, head_d;
    pipe_buf_ptr_t    tail_q, tail_d;
    logic [OCC_W-1:0] occ_q, occ_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             push, pop;

    // Handshake flags come from registered occupancy only, so in_ready never sees out_ready.
    always_comb begin
        in_ready  = (occ_q != OCC_W'(DEPTH));
        out_valid = (occ_q != '0);
        push      = in_valid && in_ready && !flush;
        pop       = out_valid && out_ready && !flush;
        head_d    = head_q;
        tail_d    = tail_q;
        occ_d     = occ_q;
        if (flush) begin
            head_d = '0;
            tail_d = '0;
            occ_d  = '0;
        end else begin
            if (push) begin
                tail_d = pipe_buf_ptr_inc(tail_q, DEPTH);
            end
            if (pop) begin
                head_d = pipe_buf_ptr_inc(head_q, DEPTH);
            end
            if (push && !pop) begin
                occ_d = occ_q + OCC_W'(1);
            end else if (pop && !push) begin
                occ_d = occ_q - OCC_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q <= '0;
            tail_q <= '0;
            occ_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            occ_q  <= occ_d;
            if (push) begin
                mem_q[tail_q[PTR_W-1:0]] <= in_data;
            end
        end
    end

    assign out_data  = mem_q[head_q[PTR_W-1:0]];
    assign occupancy = occ_q;

`ifdef PIPE_BUF_PERF_EN
    // Counters observe raw handshake conditions and deliberately ignore flush.
    pipe_buf_sat_cnt #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en_i  (in_valid && !in_ready),
        .cnt_o (stall_cnt)
    );

    pipe_buf_sat_cnt #(.CNT_W(CNT_W)) u_bubble_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en_i  (out_ready && !out_valid),
        .cnt_o (bubble_cnt)
    );
`endif

endmodule

// File: tb/tb_pipe_buf_stage.sv
// Scoreboard bench for pipe_buf_stage: a DEPTH=2 and a DEPTH=3 instance checked against queue models.
// Counter checks are compiled in when PIPE_BUF_PERF_EN is defined.
module tb_pipe_buf_stage;

    logic       clk = 1'b0;
    logic       rst_n;

    logic       fl2, iv2, ir2, ov2, or2;
    logic [7:0] di2, do2;
    logic [1:0] occ2;

    logic       fl3, iv3, ir3, ov3, or3;
    logic [7:0] di3, do3;
    logic [1:0] occ3;

`ifdef PIPE_BUF_PERF_EN
    logic [3:0]  stall2, bubble2;
    logic [15:0] stall3, bubble3;
    int          stall_m, bubble_m;
`endif

    int         total, bad;
    logic [7:0] q2[$];
    logic [7:0] q3[$];
    int         log3[$];

    always #5 clk = ~clk;

    pipe_buf_stage #(.WIDTH(8), .DEPTH(2), .CNT_W(4)) u_d2 (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (fl2),
        .in_valid  (iv2),
        .in_ready  (ir2),
        .in_data   (di2),
        .out_valid (ov2),
        .out_ready (or2),
        .out_data  (do2),
        .occupancy (occ2)
`ifdef PIPE_BUF_PERF_EN
        ,
        .stall_cnt (stall2),
        .bubble_cnt(bubble2)
`endif
    );

    pipe_buf_stage #(.WIDTH(8), .DEPTH(3), .CNT_W(16)) u_d3 (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (fl3),
        .in_valid  (iv3),
        .in_ready  (ir3),
        .in_data   (di3),
        .out_valid (ov3),
        .out_ready (or3),
        .out_data  (do3),
        .occupancy (occ3)
`ifdef PIPE_BUF_PERF_EN
        ,
        .stall_cnt (stall3),
        .bubble_cnt(bubble3)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle on the DEPTH=2 instance, check against the model, then advance the model.
    task automatic step2(input logic iv, input logic [7:0] d, input logic ordy, input logic fl);
        logic push, pop;
        @(negedge clk);
        iv2 = iv; di2 = d; or2 = ordy; fl2 = fl;
        #1;
        chk("d2 in_ready", ir2, (q2.size() != 2));
        chk("d2 out_valid", ov2, (q2.size() != 0));
        chk("d2 occupancy", occ2, q2.size());
        if (q2.size() != 0) chk("d2 out_data", do2, q2[0]);
`ifdef PIPE_BUF_PERF_EN
        chk("d2 stall_cnt", stall2, stall_m);
        chk("d2 bubble_cnt", bubble2, bubble_m);
        if (iv && q2.size() == 2 && stall_m < 15) stall_m++;
        if (ordy && q2.size() == 0 && bubble_m < 15) bubble_m++;
`endif
        push = iv && (q2.size() != 2) && !fl;
        pop  = (q2.size() != 0) && ordy && !fl;
        if (fl) q2.delete();
        else begin
            if (pop) void'(q2.pop_front());
            if (push) q2.push_back(d);
        end
    endtask

    task automatic step3(input logic iv, input logic [7:0] d, input logic ordy, output logic pushed);
        logic pop;
        @(negedge clk);
        iv3 = iv; di3 = d; or3 = ordy; fl3 = 1'b0;
        #1;
        chk("d3 in_ready", ir3, (q3.size() != 3));
        chk("d3 out_valid", ov3, (q3.size() != 0));
        chk("d3 occupancy", occ3, q3.size());
        if (q3.size() != 0) chk("d3 out_data", do3, q3[0]);
        pushed = iv && (q3.size() != 3);
        pop    = (q3.size() != 0) && ordy;
        if (pop) log3.push_back(int'(q3.pop_front()));
        if (pushed) q3.push_back(d);
    endtask

    initial begin
        logic pushed;
        int   nxt;
        total = 0; bad = 0;
        fl2 = 0; iv2 = 0; or2 = 0; di2 = '0;
        fl3 = 0; iv3 = 0; or3 = 0; di3 = '0;
`ifdef PIPE_BUF_PERF_EN
        stall_m = 0; bubble_m = 0;
`endif
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        chk("async rst out_valid", ov2, 1'b0);
        chk("async rst in_ready", ir2, 1'b1);
        chk("async rst occupancy", occ2, 0);
        chk("async rst out_data", do2, 8'h00);
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        #1;
        chk("post rst out_data d2", do2, 8'h00);
        chk("post rst out_data d3", do3, 8'h00);
        step2(0, 8'h00, 0, 0);

        // streaming at full rate
        step2(1, 8'h11, 1, 0);
        step2(1, 8'h22, 1, 0);
        step2(1, 8'h33, 1, 0);
        step2(0, 8'h00, 1, 0);
        step2(0, 8'h00, 1, 0);
        step2(0, 8'h00, 0, 0);

        // backpressure: third entry must wait, no pass-through while full
        step2(1, 8'h0A, 0, 0);
        step2(1, 8'h0B, 0, 0);
        step2(1, 8'h0C, 0, 0);
        chk("full occupancy", occ2, 2);
        step2(1, 8'h0C, 0, 0);
        step2(1, 8'h0C, 1, 0);
        step2(1, 8'h0C, 1, 0);
        step2(0, 8'h00, 1, 0);
        step2(0, 8'h00, 0, 0);

        // flush beats push and pop in the same cycle
        step2(1, 8'h77, 0, 0);
        step2(1, 8'h88, 1, 1);
        step2(0, 8'h00, 0, 0);
        chk("flush out_valid", ov2, 1'b0);
        step2(1, 8'h99, 0, 0);
        step2(0, 8'h00, 1, 0);
        step2(0, 8'h00, 0, 0);

        // reset in the middle of a transfer
        step2(1, 8'h05, 0, 0);
        step2(1, 8'h06, 0, 0);
        #2 rst_n = 1'b0;
        iv2 = 0;
        #1;
        chk("mid rst occupancy", occ2, 0);
        chk("mid rst out_valid", ov2, 1'b0);
        chk("mid rst in_ready", ir2, 1'b1);
        chk("mid rst out_data", do2, 8'h00);
        q2.delete(); q3.delete();
`ifdef PIPE_BUF_PERF_EN
        chk("mid rst stall_cnt", stall2, 0);
        stall_m = 0; bubble_m = 0;
`endif
        @(negedge clk) rst_n = 1'b1;
        step2(0, 8'h00, 0, 0);
        step2(1, 8'h42, 1, 0);
        step2(0, 8'h00, 1, 0);
        step2(0, 8'h00, 0, 0);

        // wrap on DEPTH=3 with random backpressure
        nxt = 1;
        for (int c = 0; c < 300 && log3.size() < 10; c++) begin
            step3((nxt <= 10), 8'(nxt), 1'($urandom_range(0, 1)), pushed);
            if (pushed) nxt++;
        end
        step3(0, 8'h00, 0, pushed);
        chk("wrap popped count", log3.size(), 10);
        for (int i = 0; i < log3.size() && i < 10; i++) chk("wrap order", log3[i], i + 1);

`ifdef PIPE_BUF_PERF_EN
        // stall counter saturation, unaffected by flush
        step2(1, 8'h01, 0, 0);
        step2(1, 8'h02, 0, 0);
        for (int i = 0; i < 20; i++) step2(1, 8'h03, 0, 0);
        step2(0, 8'h00, 0, 0);
        chk("stall_cnt saturated", stall2, 4'd15);
        step2(0, 8'h00, 0, 1);
        step2(0, 8'h00, 1, 0);
        step2(0, 8'h00, 1, 0);
        step2(0, 8'h00, 0, 0);
        chk("stall_cnt after flush", stall2, 4'd15);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
